// File: rtl/issue_credit_ctrl.sv
// issue_credit_ctrl
// Credit and pointer bookkeeping for the issue stage. It tracks ROB (64),
// RS (16) and LSB (8) occupancy, hands out ROB indices to issued
// instructions and recovers from mispredict flushes.
// Optional feature macro: ISSUE_SKID_EN. When it is defined, each structure
// reports full one entry early, which keeps a slot free for a registered
// issue stage.
module issue_credit_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       flush,
  input  logic       if_req,
  input  logic       if_is_mem,
  output logic       issue_grant,
  output logic [5:0] alloc_index,
  input  logic       rob_commit,
  input  logic       rs_release,
  input  logic       lsb_release,
  output logic [5:0] rob_head,
  output logic [6:0] rob_count,
  output logic [4:0] rs_count,
  output logic [3:0] lsb_count,
  output logic       rob_full,
  output logic       rs_full,
  output logic       lsb_full,
  output logic       underflow_err
);

`ifdef ISSUE_SKID_EN
  localparam logic [6:0] ROB_THRESH = 7'd63;
  localparam logic [4:0] RS_THRESH  = 5'd15;
  localparam logic [3:0] LSB_THRESH = 4'd7;
`else
  localparam logic [6:0] ROB_THRESH = 7'd64;
  localparam logic [4:0] RS_THRESH  = 5'd16;
  localparam logic [3:0] LSB_THRESH = 4'd8;
`endif

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

  state_t     state;
  logic [5:0] tail;

  logic       active;
  logic       res_ok;
  logic       rs_inc;
  logic       lsb_inc;
  logic       commit_ok;
  logic       rs_dec;
  logic       lsb_dec;
  logic       underflow_now;
  logic [6:0] rob_count_nxt;
  logic [4:0] rs_count_nxt;
  logic [3:0] lsb_count_nxt;

  assign alloc_index = tail;

  // Full flags follow the current counts, so a release in this cycle cannot free a slot for a grant in the same cycle.
  always_comb begin
    rob_full = (rob_count >= ROB_THRESH);
    rs_full  = (rs_count  >= RS_THRESH);
    lsb_full = (lsb_count >= LSB_THRESH);
  end

  // Grant an instruction only while running, unflushed, enabled, and with room in the ROB and its target structure.
  always_comb begin
    active      = rdy & ~flush & (state == RUN);
    res_ok      = if_is_mem ? ~lsb_full : ~rs_full;
    issue_grant = active & if_req & ~rob_full & res_ok;
    rs_inc      = issue_grant & ~if_is_mem;
    lsb_inc     = issue_grant & if_is_mem;
  end

  // Accept only the retirements and releases whose counter holds something; any other one flags an underflow.
  always_comb begin
    commit_ok     = active & rob_commit  & (rob_count != 7'd0);
    rs_dec        = active & rs_release  & (rs_count  != 5'd0);
    lsb_dec       = active & lsb_release & (lsb_count != 4'd0);
    underflow_now = active & ((rob_commit  & (rob_count == 7'd0)) |
                              (rs_release  & (rs_count  == 5'd0)) |
                              (lsb_release & (lsb_count == 4'd0)));
  end

  // Net occupancy change: a same-cycle grant and release cancel out.
  always_comb begin
    rob_count_nxt = rob_count + {6'd0, issue_grant} - {6'd0, commit_ok};
    rs_count_nxt  = rs_count  + {4'd0, rs_inc}      - {4'd0, rs_dec};
    lsb_count_nxt = lsb_count + {3'd0, lsb_inc}     - {3'd0, lsb_dec};
  end

  // Control FSM and all bookkeeping registers; reset wins, then rdy gates everything, then flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      rob_head      <= 6'd0;
      tail          <= 6'd0;
      rob_count     <= 7'd0;
      rs_count      <= 5'd0;
      lsb_count     <= 4'd0;
      underflow_err <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        state     <= RECOVER;
        rob_head  <= 6'd0;
        tail      <= 6'd0;
        rob_count <= 7'd0;
        rs_count  <= 5'd0;
        lsb_count <= 4'd0;
      end else begin
        case (state)
          RUN: begin
            rob_count <= rob_count_nxt;
            rs_count  <= rs_count_nxt;
            lsb_count <= lsb_count_nxt;
            if (issue_grant) begin
              tail <= tail + 6'd1;
            end
            if (commit_ok) begin
              rob_head <= rob_head + 6'd1;
            end
            if (underflow_now) begin
              underflow_err <= 1'b1;
            end
          end
          RECOVER: begin
            state <= RUN;
          end
          default: begin
            state <= RUN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_issue_credit_ctrl.sv
// tb_issue_credit_ctrl
// Drives issue_credit_ctrl with directed sequences followed by random traffic.
// A queue-based occupancy model tracks what the outputs should be, and every
// output is compared against it each cycle. Thresholds follow ISSUE_SKID_EN.
`timescale 1ns/1ps
module tb_issue_credit_ctrl;

`ifdef ISSUE_SKID_EN
  localparam int ROB_TH = 63;
  localparam int RS_TH  = 15;
  localparam int LSB_TH = 7;
`else
  localparam int ROB_TH = 64;
  localparam int RS_TH  = 16;
  localparam int LSB_TH = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rdy;
  logic       flush;
  logic       if_req;
  logic       if_is_mem;
  logic       rob_commit;
  logic       rs_release;
  logic       lsb_release;
  logic       issue_grant;
  logic [5:0] alloc_index;
  logic [5:0] rob_head;
  logic [6:0] rob_count;
  logic [4:0] rs_count;
  logic [3:0] lsb_count;
  logic       rob_full;
  logic       rs_full;
  logic       lsb_full;
  logic       underflow_err;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // The model keeps the in-flight ROB indices in age order, plus plain occupancy numbers.
  int m_rob_q[$];
  int m_head;
  int m_tail;
  int m_rs;
  int m_lsb;
  bit m_err;
  bit m_recover;
  bit m_g;

  bit last_grant;
  int last_idx;
  int grants;
  int commit_pct;

  issue_credit_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .flush        (flush),
    .if_req       (if_req),
    .if_is_mem    (if_is_mem),
    .issue_grant  (issue_grant),
    .alloc_index  (alloc_index),
    .rob_commit   (rob_commit),
    .rs_release   (rs_release),
    .lsb_release  (lsb_release),
    .rob_head     (rob_head),
    .rob_count    (rob_count),
    .rs_count     (rs_count),
    .lsb_count    (lsb_count),
    .rob_full     (rob_full),
    .rs_full      (rs_full),
    .lsb_full     (lsb_full),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  // An instruction can issue when the controller is live and both the ROB and the target structure have room.
  function automatic bit expGrant();
    bit room;
    room = if_is_mem ? (m_lsb < LSB_TH) : (m_rs < RS_TH);
    return rdy && !flush && !m_recover && if_req && (m_rob_q.size() < ROB_TH) && room;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Set the inputs for one cycle, capture the grant just before the edge, then step past the edge.
  task automatic applyStimulus(input bit r, input bit f, input bit req, input bit mem,
                               input bit cm, input bit rsr, input bit lsr);
    rdy         = r;
    flush       = f;
    if_req      = req;
    if_is_mem   = mem;
    rob_commit  = cm;
    rs_release  = rsr;
    lsb_release = lsr;
    #1;
    last_grant = issue_grant;
    last_idx   = alloc_index;
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1, 1, 1, 0, 1, 1, 1);
    rst = 1'b0;
  endtask

  // Advance the model at each rising edge, using the inputs that were stable before it.
  initial begin
    forever begin
      @(posedge clk);
      m_g = expGrant();
      if (rst) begin
        m_rob_q.delete();
        m_head = 0; m_tail = 0; m_rs = 0; m_lsb = 0;
        m_err = 0; m_recover = 0;
      end else if (rdy) begin
        if (flush) begin
          m_rob_q.delete();
          m_head = 0; m_tail = 0; m_rs = 0; m_lsb = 0;
          m_recover = 1;
        end else if (m_recover) begin
          m_recover = 0;
        end else begin
          if (rob_commit) begin
            if (m_rob_q.size() > 0) begin
              void'(m_rob_q.pop_front());
              m_head = (m_head + 1) % 64;
            end else m_err = 1;
          end
          if (rs_release) begin
            if (m_rs > 0) m_rs--; else m_err = 1;
          end
          if (lsb_release) begin
            if (m_lsb > 0) m_lsb--; else m_err = 1;
          end
          if (m_g) begin
            m_rob_q.push_back(m_tail);
            m_tail = (m_tail + 1) % 64;
            if (if_is_mem) m_lsb++; else m_rs++;
          end
        end
      end
    end
  end

  // Compare every output against the model in the middle of each cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        checkOutput("issue_grant", issue_grant, expGrant());
        checkOutput("alloc_index", alloc_index, m_tail);
        checkOutput("rob_head", rob_head, m_head);
        checkOutput("rob_count", rob_count, m_rob_q.size());
        checkOutput("rs_count", rs_count, m_rs);
        checkOutput("lsb_count", lsb_count, m_lsb);
        checkOutput("rob_full", rob_full, m_rob_q.size() >= ROB_TH);
        checkOutput("rs_full", rs_full, m_rs >= RS_TH);
        checkOutput("lsb_full", lsb_full, m_lsb >= LSB_TH);
        checkOutput("underflow_err", underflow_err, m_err);
      end
    end
  end

  initial begin
    rst = 1'b1; rdy = 1'b0; flush = 1'b0; if_req = 1'b0; if_is_mem = 1'b0;
    rob_commit = 1'b0; rs_release = 1'b0; lsb_release = 1'b0;
    @(posedge clk);
    #2;
    check_en = 1'b1;
    rst = 1'b0;

    // Reset state.
    checkOutput("reset_rob_count", rob_count, 0);
    checkOutput("reset_alloc_index", alloc_index, 0);
    checkOutput("reset_underflow", underflow_err, 0);

    // Back-to-back non-mem requests until the ROB fills.
    doReset();
    grants = 0;
    for (int i = 0; i < 65; i++) begin
      applyStimulus(1, 0, 1, 0, 0, m_rs > 0, 0);
      if (last_grant) begin
        checkOutput("fill_alloc_seq", last_idx, grants);
        grants++;
      end
    end
    checkOutput("fill_grant_total", grants, ROB_TH);
    checkOutput("fill_rob_full", rob_full, 1);
    checkOutput("fill_rob_count", rob_count, ROB_TH);
    checkOutput("fill_model_count", m_rob_q.size(), ROB_TH);

    // Commit at a full ROB whose head sits at 10, then wrap the tail.
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 1, 0, 0, m_rs > 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0, 1, m_rs > 0, 0);
    checkOutput("wrap_head_10", rob_head, 10);
    for (int i = 0; i < ROB_TH; i++) applyStimulus(1, 0, 1, 0, 0, m_rs > 0, 0);
    checkOutput("wrap_count_full", rob_count, ROB_TH);
    checkOutput("wrap_tail", alloc_index, (10 + ROB_TH) % 64);
    applyStimulus(1, 0, 0, 0, 1, m_rs > 0, 0);
    checkOutput("wrap_head_11", rob_head, 11);
    checkOutput("wrap_count_after_commit", rob_count, ROB_TH - 1);
    applyStimulus(1, 0, 1, 0, 0, m_rs > 0, 0);
    checkOutput("wrap_grant", last_grant, 1);
    checkOutput("wrap_grant_index", last_idx, (10 + ROB_TH) % 64);
    checkOutput("wrap_tail_next", alloc_index, (11 + ROB_TH) % 64);

    // A release at a full RS does not open a slot until the next cycle.
    doReset();
    for (int i = 0; i < RS_TH; i++) applyStimulus(1, 0, 1, 0, 0, 0, 0);
    checkOutput("rs_full_flag", rs_full, 1);
    applyStimulus(1, 0, 1, 0, 0, 1, 0);
    checkOutput("rs_full_same_cycle_grant", last_grant, 0);
    checkOutput("rs_count_after_release", rs_count, RS_TH - 1);
    applyStimulus(1, 0, 1, 0, 0, 0, 0);
    checkOutput("rs_next_grant", last_grant, 1);
    checkOutput("rs_count_refill", rs_count, RS_TH);

    // Flush from 20/5/3, then one RECOVER cycle, then issue from index 0.
    doReset();
    for (int i = 0; i < 5; i++)  applyStimulus(1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) applyStimulus(1, 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++)  applyStimulus(1, 0, 1, 1, 0, 0, 0);
    checkOutput("pre_flush_rob", rob_count, 20);
    checkOutput("pre_flush_rs", rs_count, 5);
    checkOutput("pre_flush_lsb", lsb_count, 3);
    applyStimulus(1, 1, 1, 0, 1, 1, 1);
    checkOutput("flush_grant", last_grant, 0);
    checkOutput("flush_rob_zero", rob_count, 0);
    checkOutput("flush_rs_zero", rs_count, 0);
    checkOutput("flush_lsb_zero", lsb_count, 0);
    applyStimulus(1, 0, 1, 0, 0, 1, 1);
    checkOutput("recover_grant", last_grant, 0);
    checkOutput("recover_no_underflow", underflow_err, 0);
    applyStimulus(1, 0, 1, 0, 0, 0, 0);
    checkOutput("post_recover_grant", last_grant, 1);
    checkOutput("post_recover_index", last_idx, 0);

    // Reset taken while in RECOVER goes straight back to running.
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    doReset();
    applyStimulus(1, 0, 1, 0, 0, 0, 0);
    checkOutput("rst_mid_recover_grant", last_grant, 1);

    // Underflow is sticky, and rdy low freezes everything.
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    checkOutput("underflow_set", underflow_err, 1);
    checkOutput("underflow_lsb_count", lsb_count, 0);
    applyStimulus(1, 0, 1, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 0, 1, 1, 1);
      checkOutput("stall_grant", last_grant, 0);
    end
    checkOutput("stall_rob_count", rob_count, 2);
    checkOutput("stall_lsb_count", lsb_count, 2);
    checkOutput("stall_alloc_index", alloc_index, 2);
    checkOutput("stall_underflow", underflow_err, 1);

    // Random traffic in phases with different retirement pressure.
    for (int i = 0; i < 3000; i++) begin
      commit_pct = ((i / 500) % 2 == 0) ? 15 : 60;
      rst = ($urandom_range(0, 299) == 0);
      applyStimulus($urandom_range(0, 9) != 0,
                    $urandom_range(0, 59) == 0,
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) == 0,
                    $urandom_range(0, 99) < commit_pct,
                    $urandom_range(0, 99) < commit_pct + 10,
                    $urandom_range(0, 99) < commit_pct + 10);
      rst = 1'b0;
    end

    doReset();
    checkOutput("final_underflow_cleared", underflow_err, 0);
    checkOutput("final_rob_count", rob_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_credit_ctrl.md
ISSUE_CREDIT_CTRL -- requirements
Module: issue_credit_ctrl

Interface
REQ-001 SHALL have ports (name direction width meaning), clock and reset first: clk in 1 clock, all state updates on posedge; rst in 1 reset, synchronous, active-high.
REQ-002 SHALL have rdy in 1 global enable; when 0 all state frozen.
REQ-003 SHALL have flush in 1 mispredict flush from CDB.
REQ-004 SHALL have if_req in 1 decoded instruction waiting to issue; if_is_mem in 1 load/store routed to LSB, else to RS.
REQ-005 SHALL have issue_grant out 1 instruction accepted this cycle (combinational); alloc_index out 6 ROB index for the granted instruction.
REQ-006 SHALL have rob_commit in 1 ROB head retired; rs_release in 1 RS entry dispatched; lsb_release in 1 LSB entry dispatched.
REQ-007 SHALL have rob_head out 6 oldest ROB index; rob_count out 7; rs_count out 5; lsb_count out 4; rob_full, rs_full, lsb_full out 1 each; underflow_err out 1 sticky.

Function
REQ-008 SHALL use depths ROB 64, RS 16, LSB 8.
REQ-009 SHALL implement FSM states RUN, RECOVER; RECOVER lasts exactly one cycle, then RUN.
REQ-010 SHALL assert issue_grant = rdy & ~flush & state==RUN & if_req & ~rob_full & (if_is_mem ? ~lsb_full : ~rs_full).
REQ-011 SHALL drive alloc_index = tail pointer; on grant tail increments, wrapping 63->0.
REQ-012 SHALL increment rob_head on rob_commit when rob_count>0, wrapping 63->0.
REQ-013 SHALL update each counter by net effect of same-cycle grant (+1) and release/commit (-1); simultaneous +1/-1 leaves count unchanged.
REQ-014 SHALL ignore a release/commit while its count is 0 and set underflow_err; counter, head unchanged.
REQ-015 SHALL derive full flags combinationally from current counts per REQ-023; no grant on a full resource even if a release occurs the same cycle.
REQ-016 SHALL, on flush (rdy=1), zero all counts, head, tail, ignore same-cycle grant/commit/release, and enter RECOVER.
REQ-017 SHALL hold issue_grant=0 throughout RECOVER; releases in RECOVER are ignored (structures already cleared).
REQ-018 SHALL, with rdy=0, hold all registers and drive issue_grant=0; flush is ignored.
REQ-019 SHALL keep count == (tail - head) mod 64 for ROB at all times, with count 64 distinguished from 0 by rob_count.

Reset
REQ-020 SHALL, on rst, set state RUN, head 0, tail 0, all counts 0, underflow_err 0; rst has priority over rdy and flush.
REQ-021 SHALL, on rst mid-stall or mid-RECOVER, return to the reset state in one cycle.
REQ-022 SHALL clear underflow_err only by rst.

Configuration
REQ-023 SHALL honour macro ISSUE_SKID_EN: defined -> full thresholds are depth-1 (ROB 63, RS 15, LSB 7), reserving one slot for the registered issue stage; undefined -> thresholds are depth (64, 16, 8).

Verification
REQ-024 SHALL cover: rst, then 64 back-to-back if_req (non-mem, RS releasing each cycle), macro undefined -> grants 64, alloc_index 0..63, rob_full=1, 65th not granted.
REQ-025 SHALL cover: same as REQ-024 with ISSUE_SKID_EN -> grants stop at 63, rob_full at rob_count=63.
REQ-026 SHALL cover: rob_count=64, head=10, rob_commit -> head=11, count 63, next grant gets index tail(10), wraps correctly.
REQ-027 SHALL cover: rs_count=16, if_req non-mem + rs_release same cycle -> no grant, rs_count=15; next cycle grant, rs_count=16.
REQ-028 SHALL cover: counts 20/5/3, flush with if_req -> no grant, all counts 0, next cycle no grant (RECOVER), following cycle grant with alloc_index 0.
REQ-029 SHALL cover: lsb_release at lsb_count=0 -> underflow_err=1, stays 1 until rst; rdy=0 for 3 cycles with if_req -> no state change.
